// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: drives a combinational instruction memory from a
// word-aligned fetch PC and buffers fetched words in a 2-entry FIFO toward the
// decode stage. Redirects flush the buffer and reload the PC.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic [1:0]  buf_count
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned CNTW = 2;
   localparam logic [XLEN-1:0] ALIGN_MASK       = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;
   localparam logic [XLEN-1:0] PC_STEP          = XLEN'(4);

   // One buffered fetch: the word and the byte address it came from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   // Buffer occupancy doubles as the controller state.
   typedef enum logic [CNTW-1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   occ_e            occ_q, occ_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   fetch_entry_t    head_q, head_d;
   fetch_entry_t    tail_q, tail_d;

   fetch_entry_t    new_entry_c;
   logic            has_data_c;
   logic            pop_c;
   logic            push_c;

   // Handshake qualifiers; a redirect blocks both pop and push in its cycle.
   always_comb begin
      has_data_c  = (occ_q != OCC_EMPTY);
      pop_c       = has_data_c & ~redirect_valid & inst_ready;
      push_c      = fetch_en & ~redirect_valid & ((occ_q != OCC_FULL) | pop_c);
      new_entry_c = '{pc: fetch_pc_q, inst: imem_data};
   end

   // Next-state: redirect first, otherwise advance PC on push and update the FIFO.
   always_comb begin
      occ_d      = occ_q;
      fetch_pc_d = fetch_pc_q;
      head_d     = head_q;
      tail_d     = tail_q;

      if (redirect_valid) begin
         occ_d      = OCC_EMPTY;
         fetch_pc_d = redirect_pc & ALIGN_MASK;
      end else begin
         if (push_c) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end

         unique case (occ_q)
            OCC_EMPTY: begin
               if (push_c) begin
                  head_d = new_entry_c;
                  occ_d  = OCC_ONE;
               end
            end
            OCC_ONE: begin
               case ({push_c, pop_c})
                  2'b11: head_d = new_entry_c;
                  2'b10: begin
                     tail_d = new_entry_c;
                     occ_d  = OCC_FULL;
                  end
                  2'b01: occ_d = OCC_EMPTY;
                  default: occ_d = OCC_ONE;
               endcase
            end
            OCC_FULL: begin
               // A push into a full buffer is only possible alongside a pop.
               if (pop_c) begin
                  head_d = tail_q;
                  if (push_c) begin
                     tail_d = new_entry_c;
                  end else begin
                     occ_d = OCC_ONE;
                  end
               end
            end
            default: occ_d = OCC_EMPTY;
         endcase
      end
   end

   // State registers with asynchronous clear; head clears so outputs read zero in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q      <= OCC_EMPTY;
         fetch_pc_q <= RESET_PC_ALIGNED;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         occ_q      <= occ_d;
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Outputs come straight from registers; only inst_valid sees the redirect mask.
   always_comb begin
      imem_addr  = fetch_pc_q;
      inst_valid = has_data_c & ~redirect_valid;
      inst_data  = head_q.inst;
      inst_pc    = head_q.pc;
      buf_count  = CNTW'(occ_q);
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: two instances (RESET_PC 0 and FFFF_FFF8) share stimulus,
// each checked every cycle against a queue-based model plus directed literal checks.
module tb_imem_fetch_ctrl;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fe = 1'b0;
   logic        ry = 1'b0;
   logic        redir = 1'b0;
   logic [31:0] rpc = 32'h0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] fe_pat  = 16'b1101_1111_0111_1011;
   logic [15:0] ry_pat  = 16'b1010_0110_1100_1011;
   logic [15:0] rd_pat  = 16'b0000_0100_0011_0000;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s u%0d act=%h exp=%h t=%0t", nm, u, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam logic [31:0] RPC = (g == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;

      logic [31:0] addr, data, ipc, idata;
      logic        ivalid;
      logic [1:0]  cnt;

      // Memory word k holds value k.
      assign data = addr >> 2;

      imem_fetch_ctrl #(.RESET_PC(RPC)) dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .fetch_en      (fe),
         .redirect_valid(redir),
         .redirect_pc   (rpc),
         .imem_addr     (addr),
         .imem_data     (data),
         .inst_valid    (ivalid),
         .inst_ready    (ry),
         .inst_data     (idata),
         .inst_pc       (ipc),
         .buf_count     (cnt)
      );

      ent_t        mq[$];
      logic [31:0] mpc;
      bit          m_pop, m_push;
      ent_t        e;

      // Behavioural model: queue of fetched words and a fetch address.
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mq.delete();
            mpc = RPC & 32'hFFFF_FFFC;
         end else if (redir) begin
            mq.delete();
            mpc = rpc & 32'hFFFF_FFFC;
         end else begin
            m_pop  = (mq.size() != 0) && ry;
            m_push = fe && ((mq.size() < 2) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
               e.pc   = mpc;
               e.inst = mpc >> 2;
               mq.push_back(e);
               mpc = mpc + 32'd4;
            end
         end
      end

      // Per-cycle comparison against the model.
      always @(negedge clk) begin
         if (!rst_n) begin
            chk("rst.valid", g, 32'(ivalid), 32'h0);
            chk("rst.cnt",   g, 32'(cnt),    32'h0);
            chk("rst.pc",    g, ipc,         32'h0);
            chk("rst.data",  g, idata,       32'h0);
            chk("rst.addr",  g, addr,        RPC & 32'hFFFF_FFFC);
         end else begin
            chk("m.valid", g, 32'(ivalid), 32'((mq.size() != 0) && !redir));
            chk("m.cnt",   g, 32'(cnt),    32'(mq.size()));
            chk("m.addr",  g, addr,        mpc);
            if (mq.size() != 0) begin
               chk("m.pc",   g, ipc,   mq[0].pc);
               chk("m.data", g, idata, mq[0].inst);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset values
      step();
      step();
      chk("r.cnt",   0, 32'(g_inst[0].cnt),    32'h0);
      chk("r.valid", 0, 32'(g_inst[0].ivalid), 32'h0);
      chk("r.data",  0, g_inst[0].idata,       32'h0);
      chk("r.addr",  0, g_inst[0].addr,        32'h0);
      chk("r.addr",  1, g_inst[1].addr,        32'hFFFF_FFF8);

      // Continuous streaming, including PC wrap on the second instance
      rst_n = 1'b1;
      fe    = 1'b1;
      ry    = 1'b1;
      step();
      chk("a.valid", 0, 32'(g_inst[0].ivalid), 32'h1);
      for (int i = 0; i < 4; i++) begin
         chk("a.pc",   0, g_inst[0].ipc,   32'(4 * i));
         chk("a.data", 0, g_inst[0].idata, 32'(i));
         chk("a.pc",   1, g_inst[1].ipc,   32'hFFFF_FFF8 + 32'(4 * i));
         step();
      end

      // Stall after reset: buffer fills to 2, then resumes without gap
      ry    = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("b.rcnt",   0, 32'(g_inst[0].cnt),    32'h0);
      chk("b.rvalid", 0, 32'(g_inst[0].ivalid), 32'h0);
      step();
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("b.cnt", 0, 32'(g_inst[0].cnt), (k < 2) ? 32'(k) : 32'd2);
      end
      chk("b.addr", 0, g_inst[0].addr, 32'h8);
      chk("b.head", 0, g_inst[0].ipc,  32'h0);
      ry = 1'b1;
      #1;
      chk("b.valid", 0, 32'(g_inst[0].ivalid), 32'h1);
      for (int k = 0; k < 4; k++) begin
         chk("b.stream", 0, g_inst[0].ipc, 32'(4 * k));
         chk("b.full",   0, 32'(g_inst[0].cnt), 32'd2);
         step();
      end

      // Redirect with buffer holding 0x10, 0x14
      chk("c.head", 0, g_inst[0].ipc, 32'h10);
      redir = 1'b1;
      rpc   = 32'h0000_0043;
      #1;
      chk("c.mask", 0, 32'(g_inst[0].ivalid), 32'h0);
      step();
      redir = 1'b0;
      chk("c.cnt",   0, 32'(g_inst[0].cnt),    32'h0);
      chk("c.addr",  0, g_inst[0].addr,        32'h40);
      chk("c.valid", 0, 32'(g_inst[0].ivalid), 32'h0);
      step();
      chk("c.valid2", 0, 32'(g_inst[0].ivalid), 32'h1);
      chk("c.pc",     0, g_inst[0].ipc,         32'h40);
      chk("c.data",   0, g_inst[0].idata,       32'h10);

      // Back-to-back redirects: the last one wins
      redir = 1'b1;
      rpc   = 32'h0000_0100;
      step();
      rpc   = 32'h0000_0207;
      step();
      redir = 1'b0;
      chk("d.addr", 0, g_inst[0].addr, 32'h204);
      step();
      chk("d.pc",   0, g_inst[0].ipc,   32'h204);
      chk("d.data", 0, g_inst[0].idata, 32'h81);

      // fetch_en low freezes PC while pops drain; ready on empty is harmless
      fe = 1'b0;
      step();
      chk("e.cnt",  0, 32'(g_inst[0].cnt), 32'h0);
      chk("e.addr", 0, g_inst[0].addr,     32'h208);
      step();
      chk("e.ucnt",  0, 32'(g_inst[0].cnt), 32'h0);
      chk("e.uaddr", 0, g_inst[0].addr,     32'h208);
      chk("e.uval",  0, 32'(g_inst[0].ivalid), 32'h0);

      // Mixed patterns, checked by the model each cycle
      for (int i = 0; i < 16; i++) begin
         fe    = fe_pat[i];
         ry    = ry_pat[i];
         redir = rd_pat[i];
         rpc   = 32'h0000_0300 + 32'(i * 8) + 32'h1;
         step();
      end
      redir = 1'b0;

      // Full buffer streaming, then asynchronous reset mid-cycle
      fe = 1'b1;
      ry = 1'b0;
      step();
      step();
      chk("f.fill", 0, 32'(g_inst[0].cnt), 32'd2);
      ry = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("f.cnt", 0, 32'(g_inst[0].cnt), 32'd2);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("f.rvalid", 0, 32'(g_inst[0].ivalid), 32'h0);
      chk("f.rcnt",   0, 32'(g_inst[0].cnt),    32'h0);
      chk("f.rdata",  0, g_inst[0].idata,       32'h0);
      chk("f.rpc",    0, g_inst[0].ipc,         32'h0);
      chk("f.raddr",  0, g_inst[0].addr,        32'h0);
      chk("f.raddr",  1, g_inst[1].addr,        32'hFFFF_FFF8);
      step();
      rst_n = 1'b1;
      step();
      chk("f.valid", 0, 32'(g_inst[0].ivalid), 32'h1);
      chk("f.pc",    0, g_inst[0].ipc,         32'h0);
      chk("f.pc",    1, g_inst[1].ipc,         32'hFFFF_FFF8);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
